serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial add controller around a single shared full-adder cell
//  (sum = a^b^c, carry = ab|bc|ac). Latches two WIDTH-bit operands on start,
//  drives one bit pair per clock into the cell LSB-first, and recirculates carry
//  through a register. Assembles the result and flags completion.
//  Trades latency for area wherever a ripple-carry adder is too large.
// PARAMETERS
//  WIDTH  8  operand/result width in bits, 2..64
//  CNT_W  4  bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A; latched on accepted start
//  b      in   WIDTH  operand B; latched on accepted start
//  cin    in   1      carry-in; latched on accepted start
//  busy   out  1      1 in RUN and DONE
//  done   out  1      single-cycle pulse; sum/cout valid
//  sum    out  WIDTH  result; held until the next accepted start
//  cout   out  1      final carry-out; held with sum
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, count=0, carry reg=0.
//  - FSM:
//    - IDLE: start=1 -> load A/B shift regs and carry reg (cin), count=0 -> RUN.
//      start=0 -> stay in IDLE.
//    - RUN: each cycle:
//      - s = A[0]^B[0]^carry; carry <= A[0]&B[0] | B[0]&carry | A[0]&carry.
//      - s shifts into the MSB of the result reg. A and B shift right.
//      - count++.
//      - After the cycle with count==WIDTH-1 -> DONE (exactly WIDTH RUN cycles).
//    - DONE: done=1; sum=result reg, cout=carry reg are registered. Next cycle -> IDLE.
//  - Latency: start sampled at edge N -> done high in cycle N+WIDTH+1.
//    Back-to-back throughput is one op per WIDTH+2 cycles.
//  - start while busy (RUN or DONE) is ignored. It is not queued.
//    a/b/cin changes during busy have no effect.
//  - sum/cout change only on DONE entry or reset. They are stable in IDLE.
//  - Carry wrap: the carry out of the MSB goes to cout only; the result wraps mod 2**WIDTH.
//  - rst mid-RUN aborts the op: next cycle IDLE, all outputs 0, no done pulse.
//  - rst and start in the same cycle: rst wins; start is discarded.
//  - Counter never exceeds WIDTH-1. The RUN->DONE compare uses full CNT_W bits.
// CONFIGURATION
//  SERIAL_ADD_SUB_EN defined:
//    - Adds an extra input port `sub` (1 bit), latched on start.
//    - sub=1: the B shift reg loads ~b and the carry reg loads 1 (cin ignored).
//    - Result is a-b mod 2**WIDTH; cout=1 means no borrow.
//    - sub=0: identical to the add path.
//  SERIAL_ADD_SUB_EN undefined:
//    - No `sub` port; add only.
//    - Same latency and reset behaviour.
// TESTING (WIDTH=8)
//  1. a=0x5A b=0x3C cin=0, start 1 cycle -> done exactly 9 cycles later;
//     sum=0x96 cout=0; busy=1 for 9 cycles.
//  2. a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 (wrap); then a=0x00 b=0x00 cin=1
//     -> sum=0x01 cout=0.
//  3. start held high continuously with a=0x01 b=0x01 -> one done every 10 cycles,
//     sum=0x02; mid-RUN changes to a/b do not alter the result.
//  4. rst=1 at 4th RUN cycle of a=0x80 b=0x80 -> next cycle busy=0, sum=0,
//     cout=0, no done; new start a=0x80 b=0x80 -> sum=0x00 cout=1.
//  5. rst=1 and start=1 same cycle -> stays IDLE, busy=0.
//  6. (SERIAL_ADD_SUB_EN) sub=1 a=0x10 b=0x01 -> sum=0x0F cout=1;
//     a=0x00 b=0x01 -> sum=0xFF cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder driving one full-adder cell LSB-first with a recirculated carry.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the `sub` input).
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q, res_d, sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q, carry_d, bit_s, busy_q, done_q, cout_q, sub_w;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    always_comb begin
        bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d = (a_q[0] & b_q[0]) | (b_q[0] & carry_q) | (a_q[0] & carry_q);
        res_d   = {bit_s, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= sub_w ? ~b : b;
                    carry_q <= sub_w ? 1'b1 : cin;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                    // Last bit: publish the fully assembled result straight from the cell.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table, hand-sequence and random checks of serial_adder_ctrl against an arithmetic model.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin, sub;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    typedef struct {
        logic [W-1:0] a, b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
    } vec_t;
    vec_t tbl[7];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, y, input logic ci, sb);
        if (sb) return {(x >= y) ? 1'b1 : 1'b0, W'(x - y)};
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    task automatic do_op(input logic [W-1:0] av, bv, input logic ci, sb, input logic [W-1:0] es, input logic eco, input string nm);
        int lat;
        bit dropped;
        lat = 0;
        dropped = 0;
        a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
        step();
        start = 1'b0;
        check({nm, " busy_start"}, busy, 1);
        while (!done && lat < W + 4) begin
            if (!busy) dropped = 1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            sub = 1'($urandom); start = 1'($urandom);
            step();
            lat++;
        end
        start = 1'b0;
        check({nm, " latency"}, lat, W);
        check({nm, " busy_run"}, dropped, 0);
        check({nm, " sum"}, sum, es);
        check({nm, " cout"}, cout, eco);
        check({nm, " busy_done"}, busy, 1);
        step();
        check({nm, " done_pulse"}, done, 0);
        check({nm, " idle"}, busy, 0);
        step();
        check({nm, " sum_hold"}, sum, es);
        check({nm, " cout_hold"}, cout, eco);
    endtask

    initial begin
        logic [W:0] r;
        int t, t1, t2;
        bit seen;
        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tbl[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step(); step();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        rst = 1'b0;
        step();

        foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0, tbl[i].s, tbl[i].co, $sformatf("tbl%0d", i));

        // start held high: one result every W+2 cycles, operands scrambled while busy
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        t = 0; t1 = -1; t2 = -1;
        while (t < 5 * W && t2 < 0) begin
            step();
            t++;
            if (done) begin
                check("held sum", sum, 8'h02);
                if (t1 < 0) t1 = t; else t2 = t;
            end
            a = (busy && !done) ? W'($urandom) : 8'h01;
            b = (busy && !done) ? W'($urandom) : 8'h01;
        end
        start = 1'b0;
        check("held period", t2 - t1, W + 2);
        step(); step();

        // reset in the 4th RUN cycle aborts without a done pulse
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        check("abort done", done, 0);
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            step();
            if (done || busy) seen = 1;
        end
        check("abort quiet", seen, 0);
        do_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, "after_abort");

        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;
        step();
        rst = 1'b0; start = 1'b0;
        check("rst_start busy", busy, 0);
        step();
        check("rst_start idle", busy, 0);
        check("rst_start done", done, 0);

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_pos");
        do_op(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, "sub_borrow");
`endif

        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, r[W-1:0], r[W], $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
